axi_lite_arbiter: RTL and testbench
===================================

// Module: axi_lite_arbiter
// PURPOSE
//  2-master -> 1-slave AXI-Lite arbiter; the upstream counterpart of the address-decoding crossbar.
//  Merges IFU (m0) and LSU (m1) onto the single master port that feeds the crossbar.
//  Exactly one transaction (read or write) is outstanding at a time; the response returns to its owner.
// PARAMETERS
//  ADDR_W  32  address width, all ports
//  DATA_W  32  data width, all ports
//  STRB_W  8   write-strobe width (matches crossbar s_wstrb)
// PORTS
//  clk                                            in   1       clock, all logic on posedge
//  rst                                            in   1       asynchronous, active-low reset
//  m{0,1}_araddr / m{0,1}_arvalid                 in   32/1    read address per master
//  m{0,1}_arready                                 out  1       read address accept
//  m{0,1}_rdata / m{0,1}_rresp / m{0,1}_rvalid    out  32/2/1  read data back to the owning master
//  m{0,1}_rready                                  in   1       read data accept
//  m{0,1}_awaddr / m{0,1}_awvalid                 in   32/1    write address
//  m{0,1}_awready                                 out  1       write address accept
//  m{0,1}_wdata / m{0,1}_wstrb / m{0,1}_wvalid    in   32/8/1  write data
//  m{0,1}_wready                                  out  1       write data accept
//  m{0,1}_bresp / m{0,1}_bvalid                   out  2/1     write response
//  m{0,1}_bready                                  in   1       write response accept
//  s_araddr, s_arvalid, s_rready, s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready
//                                                 out  -       downstream master side, widths as above
//  s_arready, s_rdata, s_rresp, s_rvalid, s_awready, s_wready, s_bresp, s_bvalid
//                                                 in   -       downstream responses
// BEHAVIOUR
//  - FSM states: IDLE, AR, R, AW_W, B. Registers: state, gnt (1b), last_gnt (1b), aw_done, w_done.
//  - Reset (rst=0, async): state=IDLE, gnt=0, last_gnt=1, aw_done=w_done=0. Every output is 0 while in IDLE.
//  - IDLE: req_i = m_i_arvalid | m_i_awvalid. Winner is registered into gnt.
//      Next state is AW_W if winner awvalid=1 (write beats read within one master), else AR.
//      1-cycle arbitration latency; no port is forwarded in IDLE.
//  - AR: s_ar* = gnt master ar*; m_gnt_arready = s_arready. On arvalid&arready -> R.
//  - R: m_gnt_r{data,resp,valid} = s_r*; s_rready = m_gnt_rready. On rvalid&rready -> IDLE, last_gnt=gnt.
//  - AW_W: AW and W forwarded independently. Each handshake sets its done flag and masks its valid/ready.
//      When both are done (same or different cycles) -> B and both flags clear.
//  - B: m_gnt_b* = s_b*; s_bready = m_gnt_bready. On bvalid&bready -> IDLE, last_gnt=gnt.
//  - Non-granted master: all its ready/valid outputs are 0; rdata/bresp are 0; its valids stay pending.
//  - Response data passes combinationally; zero added latency outside IDLE.
//  - s_* valid never drops before its handshake once asserted (held by the FSM state).
//  - DECERR (2'b11) from downstream is forwarded unchanged; no retry.
//  - Masters must hold valid until ready (AXI rule); a request withdrawn in IDLE is simply not granted.
//  - Reset mid-transaction aborts to IDLE; outputs go to 0 immediately (async).
// CONFIGURATION
//  ARB_RR_EN defined: round-robin; on simultaneous requests the master != last_gnt wins.
//  ARB_RR_EN undefined: fixed priority, m1 (LSU) always beats m0 (IFU); last_gnt kept but unused.
// STRUCTURE
//  Shared package axi_lite_pkg: FSM state encoding and RESP_OKAY=2'b00 / RESP_DECERR=2'b11 constants.
//  Sub-module arb_pick2 (req[1:0], last_gnt -> gnt, any) holds both arbitration policies under ARB_RR_EN.
// TESTING
//  1 m0 read 0x80000000 alone: arready@T+1, rdata 0x12345678 routed to m0; m1 r* stays 0.
//  2 m0 and m1 read in the same cycle: RR grants m1 then m0; fixed priority gives m1 twice if m1 re-requests.
//  3 m1 write: awvalid at T, wvalid at T+3 -> s_awvalid drops after its handshake; s_wvalid forwarded at T+3;
//    bvalid goes only to m1, bresp 00.
//  4 m1 read 0x00000000 with downstream DECERR -> m1_rresp=2'b11; FSM back in IDLE the next cycle.
//  5 rst low while in R with rvalid pending -> all outputs 0 at once; after release, fresh m0 read succeeds.
//  6 m1 asserts arvalid and awvalid together -> write served first, then read; no stray s_arvalid in AW_W.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_pkg
// Shared definitions for the AXI-Lite interconnect blocks.
//   state_t     : arbiter FSM state encoding
//   RESP_OKAY   : AXI response code 2'b00
//   RESP_DECERR : AXI response code 2'b11 (passed through, never generated)
// ---------------------------------------------------------------------------
package axi_lite_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_AR   = 3'd1,
      ST_R    = 3'd2,
      ST_AW_W = 3'd3,
      ST_B    = 3'd4
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_arbiter_arb_pick2.sv
// ---------------------------------------------------------------------------
// arb_pick2
// Two-requester arbitration decision (purely combinational).
// Build option: ARB_RR_EN
//   defined   : round-robin, on a tie the requester != i_last_gnt wins
//   undefined : fixed priority, requester 1 always wins
// Ports:
//   i_req[1:0]  in   request per master
//   i_last_gnt  in   master served by the previous transaction
//   o_gnt       out  index of the winning master
//   o_any       out  at least one request present
// ---------------------------------------------------------------------------
module arb_pick2 (
   input  logic [1:0] i_req,
   input  logic       i_last_gnt,
   output logic       o_gnt,
   output logic       o_any
);

   assign o_any = |i_req;

`ifdef ARB_RR_EN
   // On a tie hand the grant to whoever was not served last time.
   assign o_gnt = (&i_req) ? ~i_last_gnt : i_req[1];
`else
   // Fixed priority ignores the history bit; it is kept only for the RR build.
   logic w_unused_last_gnt;
   assign w_unused_last_gnt = i_last_gnt;
   assign o_gnt = i_req[1];
`endif

endmodule

// File: rtl/axi_lite_arbiter.sv
// ---------------------------------------------------------------------------
// axi_lite_arbiter
// Merges two AXI-Lite masters (m0 = IFU, m1 = LSU) onto one downstream port.
// One transaction (read or write) is in flight at a time; the response is
// routed back to the owning master. All outputs are 0 while idle.
// Build option: ARB_RR_EN (round-robin instead of fixed m1 priority).
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   m{0,1}_ar*/r*/aw*/w*/b*     upstream AXI-Lite slave ports
//   s_ar*/r*/aw*/w*/b*          downstream AXI-Lite master port
// ---------------------------------------------------------------------------
module axi_lite_arbiter
   import axi_lite_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int STRB_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   // master 0
   input  logic [ADDR_W-1:0] m0_araddr,
   input  logic              m0_arvalid,
   output logic              m0_arready,
   output logic [DATA_W-1:0] m0_rdata,
   output logic [1:0]        m0_rresp,
   output logic              m0_rvalid,
   input  logic              m0_rready,
   input  logic [ADDR_W-1:0] m0_awaddr,
   input  logic              m0_awvalid,
   output logic              m0_awready,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [STRB_W-1:0] m0_wstrb,
   input  logic              m0_wvalid,
   output logic              m0_wready,
   output logic [1:0]        m0_bresp,
   output logic              m0_bvalid,
   input  logic              m0_bready,
   // master 1
   input  logic [ADDR_W-1:0] m1_araddr,
   input  logic              m1_arvalid,
   output logic              m1_arready,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [1:0]        m1_rresp,
   output logic              m1_rvalid,
   input  logic              m1_rready,
   input  logic [ADDR_W-1:0] m1_awaddr,
   input  logic              m1_awvalid,
   output logic              m1_awready,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic [STRB_W-1:0] m1_wstrb,
   input  logic              m1_wvalid,
   output logic              m1_wready,
   output logic [1:0]        m1_bresp,
   output logic              m1_bvalid,
   input  logic              m1_bready,
   // downstream
   output logic [ADDR_W-1:0] s_araddr,
   output logic              s_arvalid,
   input  logic              s_arready,
   input  logic [DATA_W-1:0] s_rdata,
   input  logic [1:0]        s_rresp,
   input  logic              s_rvalid,
   output logic              s_rready,
   output logic [ADDR_W-1:0] s_awaddr,
   output logic              s_awvalid,
   input  logic              s_awready,
   output logic [DATA_W-1:0] s_wdata,
   output logic [STRB_W-1:0] s_wstrb,
   output logic              s_wvalid,
   input  logic              s_wready,
   input  logic [1:0]        s_bresp,
   input  logic              s_bvalid,
   output logic              s_bready
);

   state_t r_state, w_nxt_state;
   logic   r_gnt, w_nxt_gnt;
   logic   r_last_gnt, w_nxt_last_gnt;
   logic   r_aw_done, w_nxt_aw_done;
   logic   r_w_done, w_nxt_w_done;

   logic   w_pick, w_any;
   logic   w_aw_fire, w_w_fire;

   // Request lines of whichever master currently owns the bus.
   logic [ADDR_W-1:0] w_araddr, w_awaddr;
   logic [DATA_W-1:0] w_wdata;
   logic [STRB_W-1:0] w_wstrb;
   logic              w_arvalid, w_awvalid, w_wvalid, w_rready, w_bready;

   assign w_araddr  = r_gnt ? m1_araddr  : m0_araddr;
   assign w_arvalid = r_gnt ? m1_arvalid : m0_arvalid;
   assign w_awaddr  = r_gnt ? m1_awaddr  : m0_awaddr;
   assign w_awvalid = r_gnt ? m1_awvalid : m0_awvalid;
   assign w_wdata   = r_gnt ? m1_wdata   : m0_wdata;
   assign w_wstrb   = r_gnt ? m1_wstrb   : m0_wstrb;
   assign w_wvalid  = r_gnt ? m1_wvalid  : m0_wvalid;
   assign w_rready  = r_gnt ? m1_rready  : m0_rready;
   assign w_bready  = r_gnt ? m1_bready  : m0_bready;

   arb_pick2 u_pick (
      .i_req      ({m1_arvalid | m1_awvalid, m0_arvalid | m0_awvalid}),
      .i_last_gnt (r_last_gnt),
      .o_gnt      (w_pick),
      .o_any      (w_any)
   );

   // A channel that already handshook keeps its valid/ready masked.
   assign w_aw_fire = w_awvalid & ~r_aw_done & s_awready;
   assign w_w_fire  = w_wvalid  & ~r_w_done  & s_wready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_gnt      <= 1'b0;
         r_last_gnt <= 1'b1;
         r_aw_done  <= 1'b0;
         r_w_done   <= 1'b0;
      end else begin
         r_state    <= w_nxt_state;
         r_gnt      <= w_nxt_gnt;
         r_last_gnt <= w_nxt_last_gnt;
         r_aw_done  <= w_nxt_aw_done;
         r_w_done   <= w_nxt_w_done;
      end
   end

   always_comb begin
      w_nxt_state    = r_state;
      w_nxt_gnt      = r_gnt;
      w_nxt_last_gnt = r_last_gnt;
      w_nxt_aw_done  = r_aw_done;
      w_nxt_w_done   = r_w_done;

      m0_arready = 1'b0;  m1_arready = 1'b0;
      m0_rdata   = '0;    m1_rdata   = '0;
      m0_rresp   = RESP_OKAY;  m1_rresp = RESP_OKAY;
      m0_rvalid  = 1'b0;  m1_rvalid  = 1'b0;
      m0_awready = 1'b0;  m1_awready = 1'b0;
      m0_wready  = 1'b0;  m1_wready  = 1'b0;
      m0_bresp   = RESP_OKAY;  m1_bresp = RESP_OKAY;
      m0_bvalid  = 1'b0;  m1_bvalid  = 1'b0;

      s_araddr  = '0;
      s_arvalid = 1'b0;
      s_rready  = 1'b0;
      s_awaddr  = '0;
      s_awvalid = 1'b0;
      s_wdata   = '0;
      s_wstrb   = '0;
      s_wvalid  = 1'b0;
      s_bready  = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_nxt_gnt = w_pick;
               // Within one master a pending write is served before a read.
               if (w_pick ? m1_awvalid : m0_awvalid) w_nxt_state = ST_AW_W;
               else                                  w_nxt_state = ST_AR;
            end
         end

         ST_AR: begin
            s_araddr  = w_araddr;
            s_arvalid = w_arvalid;
            if (r_gnt) m1_arready = s_arready;
            else       m0_arready = s_arready;
            if (w_arvalid && s_arready) w_nxt_state = ST_R;
         end

         ST_R: begin
            s_rready = w_rready;
            if (r_gnt) begin
               m1_rdata = s_rdata;  m1_rresp = s_rresp;  m1_rvalid = s_rvalid;
            end else begin
               m0_rdata = s_rdata;  m0_rresp = s_rresp;  m0_rvalid = s_rvalid;
            end
            if (s_rvalid && w_rready) begin
               w_nxt_state    = ST_IDLE;
               w_nxt_last_gnt = r_gnt;
            end
         end

         ST_AW_W: begin
            s_awaddr  = w_awaddr;
            s_awvalid = w_awvalid & ~r_aw_done;
            s_wdata   = w_wdata;
            s_wstrb   = w_wstrb;
            s_wvalid  = w_wvalid & ~r_w_done;
            if (r_gnt) begin
               m1_awready = s_awready & ~r_aw_done;
               m1_wready  = s_wready  & ~r_w_done;
            end else begin
               m0_awready = s_awready & ~r_aw_done;
               m0_wready  = s_wready  & ~r_w_done;
            end
            if ((r_aw_done | w_aw_fire) && (r_w_done | w_w_fire)) begin
               w_nxt_state   = ST_B;
               w_nxt_aw_done = 1'b0;
               w_nxt_w_done  = 1'b0;
            end else begin
               w_nxt_aw_done = r_aw_done | w_aw_fire;
               w_nxt_w_done  = r_w_done  | w_w_fire;
            end
         end

         ST_B: begin
            s_bready = w_bready;
            if (r_gnt) begin
               m1_bresp = s_bresp;  m1_bvalid = s_bvalid;
            end else begin
               m0_bresp = s_bresp;  m0_bvalid = s_bvalid;
            end
            if (s_bvalid && w_bready) begin
               w_nxt_state    = ST_IDLE;
               w_nxt_last_gnt = r_gnt;
            end
         end

         default: w_nxt_state = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_arbiter
// Directed bench for axi_lite_arbiter. The downstream slave is driven by hand
// cycle by cycle; expected values are written out per step. Expectations for
// simultaneous requests follow ARB_RR_EN.
// ---------------------------------------------------------------------------
module tb_axi_lite_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] m0_araddr, m1_araddr, m0_awaddr, m1_awaddr;
   logic        m0_arvalid, m1_arvalid, m0_awvalid, m1_awvalid;
   logic        m0_arready, m1_arready, m0_awready, m1_awready;
   logic [31:0] m0_rdata, m1_rdata, m0_wdata, m1_wdata;
   logic [1:0]  m0_rresp, m1_rresp, m0_bresp, m1_bresp;
   logic        m0_rvalid, m1_rvalid, m0_rready, m1_rready;
   logic [7:0]  m0_wstrb, m1_wstrb;
   logic        m0_wvalid, m1_wvalid, m0_wready, m1_wready;
   logic        m0_bvalid, m1_bvalid, m0_bready, m1_bready;
   logic [31:0] s_araddr, s_awaddr, s_rdata, s_wdata;
   logic        s_arvalid, s_arready, s_rvalid, s_rready;
   logic        s_awvalid, s_awready, s_wvalid, s_wready;
   logic        s_bvalid, s_bready;
   logic [1:0]  s_rresp, s_bresp;
   logic [7:0]  s_wstrb;

   int n_pass  = 0;
   int n_total = 0;

`ifdef ARB_RR_EN
   localparam logic RR = 1'b1;
`else
   localparam logic RR = 1'b0;
`endif

   always #5 clk = ~clk;

   axi_lite_arbiter #(.ADDR_W(32), .DATA_W(32), .STRB_W(8)) dut (
      .clk(clk), .rst(rst),
      .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
      .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
      .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
      .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
      .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
      .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
      .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
      .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
      .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
      .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      m0_araddr = '0; m1_araddr = '0; m0_awaddr = '0; m1_awaddr = '0;
      m0_arvalid = 0; m1_arvalid = 0; m0_awvalid = 0; m1_awvalid = 0;
      m0_wdata = '0; m1_wdata = '0; m0_wstrb = '0; m1_wstrb = '0;
      m0_wvalid = 0; m1_wvalid = 0;
      m0_rready = 0; m1_rready = 0; m0_bready = 0; m1_bready = 0;
      s_arready = 1; s_awready = 1; s_wready = 1;
      s_rdata = '0; s_rresp = '0; s_rvalid = 0; s_bresp = '0; s_bvalid = 0;

      // reset
      repeat (2) @(posedge clk);
      #1;
      check("rst_s_arvalid", s_arvalid, 0);
      check("rst_s_awvalid", s_awvalid, 0);
      check("rst_m0_arready", m0_arready, 0);
      rst = 1'b1;
      tick();

      // 1: m0 read alone
      m0_araddr = 32'h8000_0000; m0_arvalid = 1; #1;
      check("t1_idle_arready", m0_arready, 0);
      check("t1_idle_s_arvalid", s_arvalid, 0);
      tick();
      check("t1_s_arvalid", s_arvalid, 1);
      check("t1_s_araddr", s_araddr, 32'h8000_0000);
      check("t1_m0_arready", m0_arready, 1);
      check("t1_m1_arready", m1_arready, 0);
      tick();
      m0_arvalid = 0; s_rvalid = 1; s_rdata = 32'h1234_5678; s_rresp = 2'b00; m0_rready = 1; #1;
      check("t1_m0_rvalid", m0_rvalid, 1);
      check("t1_m0_rdata", m0_rdata, 32'h1234_5678);
      check("t1_m1_rvalid", m1_rvalid, 0);
      check("t1_m1_rdata", m1_rdata, 0);
      check("t1_s_rready", s_rready, 1);
      tick();
      check("t1_idle_rvalid", m0_rvalid, 0);
      s_rvalid = 0; m0_rready = 0; s_rdata = '0;

      // 2: simultaneous reads (last winner was m0, so both policies pick m1)
      m0_araddr = 32'h1000; m0_arvalid = 1; m1_araddr = 32'h2000; m1_arvalid = 1; #1;
      tick();
      check("t2a_m1_arready", m1_arready, 1);
      check("t2a_m0_arready", m0_arready, 0);
      check("t2a_s_araddr", s_araddr, 32'h2000);
      tick();
      m1_arvalid = 0; s_rvalid = 1; s_rdata = 32'hAAAA_5555; m1_rready = 1; #1;
      check("t2a_m1_rdata", m1_rdata, 32'hAAAA_5555);
      check("t2a_m0_rvalid", m0_rvalid, 0);
      tick();
      s_rvalid = 0; m1_rready = 0; m1_arvalid = 1; #1;
      tick();
      check("t2b_m0_arready", m0_arready, RR);
      check("t2b_m1_arready", m1_arready, !RR);
      check("t2b_s_araddr", s_araddr, RR ? 32'h1000 : 32'h2000);
      tick();
      m0_arvalid = 0; m1_arvalid = 0;
      s_rvalid = 1; s_rdata = 32'h5A5A_5A5A; m0_rready = 1; m1_rready = 1; #1;
      check("t2b_m0_rvalid", m0_rvalid, RR);
      check("t2b_m1_rvalid", m1_rvalid, !RR);
      tick();
      s_rvalid = 0; m0_rready = 0; m1_rready = 0;

      // 3: m1 write, data arrives three cycles after the address
      m1_awaddr = 32'h40; m1_awvalid = 1; m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 8'h0F; #1;
      tick();
      check("t3_s_awvalid", s_awvalid, 1);
      check("t3_s_awaddr", s_awaddr, 32'h40);
      check("t3_m1_awready", m1_awready, 1);
      check("t3_m0_awready", m0_awready, 0);
      check("t3_s_wvalid_early", s_wvalid, 0);
      check("t3_s_arvalid", s_arvalid, 0);
      tick();
      m1_awvalid = 0; #1;
      check("t3_s_awvalid_done", s_awvalid, 0);
      check("t3_m1_awready_done", m1_awready, 0);
      tick();
      m1_wvalid = 1; #1;
      check("t3_s_wvalid", s_wvalid, 1);
      check("t3_s_wdata", s_wdata, 32'hDEAD_BEEF);
      check("t3_s_wstrb", s_wstrb, 8'h0F);
      check("t3_m1_wready", m1_wready, 1);
      tick();
      m1_wvalid = 0; s_bvalid = 1; s_bresp = 2'b00; m1_bready = 1; #1;
      check("t3_m1_bvalid", m1_bvalid, 1);
      check("t3_m0_bvalid", m0_bvalid, 0);
      check("t3_m1_bresp", m1_bresp, 2'b00);
      check("t3_s_bready", s_bready, 1);
      check("t3_s_wvalid_b", s_wvalid, 0);
      tick();
      check("t3_idle_bvalid", m1_bvalid, 0);
      s_bvalid = 0; m1_bready = 0;

      // 4: DECERR passthrough
      m1_araddr = 32'h0; m1_arvalid = 1; #1;
      tick();
      check("t4_m1_arready", m1_arready, 1);
      check("t4_s_araddr", s_araddr, 32'h0);
      tick();
      m1_arvalid = 0; s_rvalid = 1; s_rresp = 2'b11; s_rdata = '0; m1_rready = 1; #1;
      check("t4_m1_rresp", m1_rresp, 2'b11);
      check("t4_m1_rvalid", m1_rvalid, 1);
      tick();
      check("t4_idle_rvalid", m1_rvalid, 0);
      check("t4_idle_rresp", m1_rresp, 2'b00);
      check("t4_idle_s_rready", s_rready, 0);
      s_rvalid = 0; s_rresp = 2'b00; m1_rready = 0;

      // 5: reset while a read response is pending
      m0_araddr = 32'h3000; m0_arvalid = 1; #1;
      tick();
      tick();
      m0_arvalid = 0; s_rvalid = 1; s_rdata = 32'h77; m0_rready = 0; #1;
      check("t5_m0_rvalid_pend", m0_rvalid, 1);
      check("t5_s_rready_pend", s_rready, 0);
      #2 rst = 1'b0;
      #1;
      check("t5_rst_m0_rvalid", m0_rvalid, 0);
      check("t5_rst_m0_rdata", m0_rdata, 0);
      #2 rst = 1'b1;
      s_rvalid = 0; s_rdata = '0;
      tick();
      m0_araddr = 32'h8000_0004; m0_arvalid = 1; #1;
      tick();
      check("t5_m0_arready", m0_arready, 1);
      check("t5_s_araddr", s_araddr, 32'h8000_0004);
      tick();
      m0_arvalid = 0; s_rvalid = 1; s_rdata = 32'hCAFE_F00D; m0_rready = 1; #1;
      check("t5_m0_rdata", m0_rdata, 32'hCAFE_F00D);
      check("t5_m0_rvalid", m0_rvalid, 1);
      tick();
      s_rvalid = 0; m0_rready = 0;

      // 6: m1 read and write together, write goes first
      m1_araddr = 32'h50; m1_arvalid = 1;
      m1_awaddr = 32'h60; m1_awvalid = 1;
      m1_wdata = 32'h1234; m1_wstrb = 8'hFF; m1_wvalid = 1; #1;
      tick();
      check("t6_s_arvalid_aw", s_arvalid, 0);
      check("t6_s_awvalid", s_awvalid, 1);
      check("t6_s_wvalid", s_wvalid, 1);
      check("t6_m1_arready_aw", m1_arready, 0);
      tick();
      m1_awvalid = 0; m1_wvalid = 0; #1;
      check("t6_s_arvalid_b", s_arvalid, 0);
      check("t6_s_awvalid_b", s_awvalid, 0);
      s_bvalid = 1; s_bresp = 2'b00; m1_bready = 1; #1;
      check("t6_m1_bvalid", m1_bvalid, 1);
      tick();
      s_bvalid = 0; m1_bready = 0; #1;
      check("t6_idle_s_arvalid", s_arvalid, 0);
      tick();
      check("t6_s_arvalid", s_arvalid, 1);
      check("t6_s_araddr", s_araddr, 32'h50);
      check("t6_m1_arready", m1_arready, 1);
      tick();
      m1_arvalid = 0; s_rvalid = 1; s_rdata = 32'hBEEF; m1_rready = 1; #1;
      check("t6_m1_rdata", m1_rdata, 32'hBEEF);
      tick();
      s_rvalid = 0; m1_rready = 0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
